alu_issue_stage: RTL and testbench

- ID/EX issue register for the SimpleMIPS datapath; it is the producer end of the ALU operand/control interface.
- Decodes an instruction word plus register-file read data into ALUIn1, ALUIn2, ALUInShamt and ALUCtrl, registered once.
- Valid/ready handshake on both sides for pipeline stall; synchronous flush for branch/jump squash.

---
 rtl/alu_issue_stage_pkg.sv | 74 +++++++
 rtl/alu_issue_stage_op_decode.sv | 90 +++++++++
 rtl/alu_issue_stage.sv | 83 ++++++++
 tb/tb_alu_issue_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, opcode/funct constants and the issue payload type
// for the SimpleMIPS ID/EX issue stage.
package alu_issue_stage_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned OP_W    = 6;

    localparam logic [CTRL_W-1:0] ALUCTRL_ADD  = 5'b00000;
    localparam logic [CTRL_W-1:0] ALUCTRL_ADDU = 5'b00001;
    localparam logic [CTRL_W-1:0] ALUCTRL_SUB  = 5'b00010;
    localparam logic [CTRL_W-1:0] ALUCTRL_SUBU = 5'b00011;
    localparam logic [CTRL_W-1:0] ALUCTRL_AND  = 5'b00100;
    localparam logic [CTRL_W-1:0] ALUCTRL_OR   = 5'b00101;
    localparam logic [CTRL_W-1:0] ALUCTRL_NOR  = 5'b00110;
    localparam logic [CTRL_W-1:0] ALUCTRL_XOR  = 5'b00111;
    localparam logic [CTRL_W-1:0] ALUCTRL_SLT  = 5'b01000;
    localparam logic [CTRL_W-1:0] ALUCTRL_SLTU = 5'b01001;
    localparam logic [CTRL_W-1:0] ALUCTRL_BNE  = 5'b01010;
    localparam logic [CTRL_W-1:0] ALUCTRL_BEQ  = 5'b01011;
    localparam logic [CTRL_W-1:0] ALUCTRL_NULL = 5'b10000;
    localparam logic [CTRL_W-1:0] ALUCTRL_SLL  = 5'b10001;
    localparam logic [CTRL_W-1:0] ALUCTRL_SRL  = 5'b10010;
    localparam logic [CTRL_W-1:0] ALUCTRL_SRA  = 5'b10011;
    localparam logic [CTRL_W-1:0] ALUCTRL_LUI  = 5'b10101;
    localparam logic [CTRL_W-1:0] ALUCTRL_JAL  = 5'b10110;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FUNCT_SLL  = 6'h00;
    localparam logic [OP_W-1:0] FUNCT_SRL  = 6'h02;
    localparam logic [OP_W-1:0] FUNCT_SRA  = 6'h03;
    localparam logic [OP_W-1:0] FUNCT_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FUNCT_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FUNCT_SUB  = 6'h22;
    localparam logic [OP_W-1:0] FUNCT_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [OP_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [OP_W-1:0] FUNCT_XOR  = 6'h26;
    localparam logic [OP_W-1:0] FUNCT_NOR  = 6'h27;
    localparam logic [OP_W-1:0] FUNCT_SLT  = 6'h2A;
    localparam logic [OP_W-1:0] FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic [DATA_W-1:0]  in1;
        logic [DATA_W-1:0]  in2;
        logic [SHAMT_W-1:0] shamt;
        logic [CTRL_W-1:0]  ctrl;
    } alu_payload_t;

    function automatic alu_payload_t payload_reset();
        alu_payload_t p;
        p.in1   = '0;
        p.in2   = '0;
        p.shamt = '0;
        p.ctrl  = ALUCTRL_NULL;
        return p;
    endfunction

endpackage

// File: rtl/alu_issue_stage_op_decode.sv
// Combinational decode of instruction word + register operands into the ALU
// operand/control payload; flags undecodable op/funct values.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    output alu_payload_t      payload_c_o,
    output logic              illegal_c_o
);

    logic [OP_W-1:0]   op;
    logic [OP_W-1:0]   funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_se;
    logic [DATA_W-1:0] imm_ze;

    assign op     = instr_i[31:26];
    assign funct  = instr_i[5:0];
    assign imm    = instr_i[15:0];
    assign imm_se = {{16{imm[15]}}, imm};
    assign imm_ze = {16'h0000, imm};

    always_comb begin
        payload_c_o.in1   = rs_data_i;
        payload_c_o.in2   = '0;
        payload_c_o.shamt = '0;
        payload_c_o.ctrl  = ALUCTRL_NULL;
        illegal_c_o       = 1'b0;

        unique case (op)
            OP_RTYPE: begin
                payload_c_o.in2 = rt_data_i;
                unique case (funct)
                    FUNCT_ADD:  payload_c_o.ctrl = ALUCTRL_ADD;
                    FUNCT_ADDU: payload_c_o.ctrl = ALUCTRL_ADDU;
                    FUNCT_SUB:  payload_c_o.ctrl = ALUCTRL_SUB;
                    FUNCT_SUBU: payload_c_o.ctrl = ALUCTRL_SUBU;
                    FUNCT_AND:  payload_c_o.ctrl = ALUCTRL_AND;
                    FUNCT_OR:   payload_c_o.ctrl = ALUCTRL_OR;
                    FUNCT_XOR:  payload_c_o.ctrl = ALUCTRL_XOR;
                    FUNCT_NOR:  payload_c_o.ctrl = ALUCTRL_NOR;
                    FUNCT_SLT:  payload_c_o.ctrl = ALUCTRL_SLT;
                    FUNCT_SLTU: payload_c_o.ctrl = ALUCTRL_SLTU;
                    FUNCT_SLL: begin
                        payload_c_o.ctrl  = ALUCTRL_SLL;
                        payload_c_o.shamt = instr_i[10:6];
                    end
                    FUNCT_SRL: begin
                        payload_c_o.ctrl  = ALUCTRL_SRL;
                        payload_c_o.shamt = instr_i[10:6];
                    end
                    FUNCT_SRA: begin
                        payload_c_o.ctrl  = ALUCTRL_SRA;
                        payload_c_o.shamt = instr_i[10:6];
                    end
                    default:    illegal_c_o = 1'b1;
                endcase
            end
            OP_ADDI:  begin payload_c_o.ctrl = ALUCTRL_ADD;  payload_c_o.in2 = imm_se; end
            OP_ADDIU: begin payload_c_o.ctrl = ALUCTRL_ADDU; payload_c_o.in2 = imm_se; end
            OP_SLTI:  begin payload_c_o.ctrl = ALUCTRL_SLT;  payload_c_o.in2 = imm_se; end
            OP_SLTIU: begin payload_c_o.ctrl = ALUCTRL_SLTU; payload_c_o.in2 = imm_se; end
            OP_ANDI:  begin payload_c_o.ctrl = ALUCTRL_AND;  payload_c_o.in2 = imm_ze; end
            OP_ORI:   begin payload_c_o.ctrl = ALUCTRL_OR;   payload_c_o.in2 = imm_ze; end
            OP_XORI:  begin payload_c_o.ctrl = ALUCTRL_XOR;  payload_c_o.in2 = imm_ze; end
            OP_LUI:   begin payload_c_o.ctrl = ALUCTRL_LUI;  payload_c_o.in2 = {imm, 16'h0000}; end
            OP_LW, OP_SW: begin
                payload_c_o.ctrl = ALUCTRL_ADD;
                payload_c_o.in2  = imm_se;
            end
            OP_BEQ:   begin payload_c_o.ctrl = ALUCTRL_BEQ;  payload_c_o.in2 = rt_data_i; end
            OP_BNE:   begin payload_c_o.ctrl = ALUCTRL_BNE;  payload_c_o.in2 = rt_data_i; end
            OP_JAL: begin
                payload_c_o.ctrl = ALUCTRL_JAL;
                payload_c_o.in1  = '0;
                payload_c_o.in2  = pc_plus4_i;
            end
            default:  illegal_c_o = 1'b1;
        endcase

        // Undecodable entries carry a neutral payload so EX does no work on them.
        if (illegal_c_o) begin
            payload_c_o = payload_reset();
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: one-deep valid/ready stage holding the decoded ALU
// payload, with synchronous flush for branch/jump squash.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          InValid,
    output logic          InReady,
    input  logic [DW-1:0] Instr,
    input  logic [DW-1:0] RsData,
    input  logic [DW-1:0] RtData,
    input  logic [DW-1:0] PcPlus4,
    input  logic          Flush,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] ALUIn1,
    output logic [DW-1:0] ALUIn2,
    output logic [4:0]    ALUInShamt,
    output logic [4:0]    ALUCtrl,
    output logic          Illegal
);

    alu_payload_t dec_payload;
    logic         dec_illegal;
    logic         accept;

    alu_payload_t payload_d, payload_q;
    logic         illegal_d, illegal_q;
    logic         valid_d,   valid_q;

    alu_op_decode u_decode (
        .instr_i     (Instr),
        .rs_data_i   (RsData),
        .rt_data_i   (RtData),
        .pc_plus4_i  (PcPlus4),
        .payload_c_o (dec_payload),
        .illegal_c_o (dec_illegal)
    );

    // Ready whenever the slot is empty or being drained this cycle.
    assign InReady = ~valid_q | OutReady;
    assign accept  = InValid & InReady & ~Flush;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        illegal_d = illegal_q;
        if (Flush) begin
            valid_d   = 1'b0;
            payload_d = payload_reset();
            illegal_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            payload_d = dec_payload;
            illegal_d = dec_illegal;
        end else if (OutReady) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= payload_reset();
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            illegal_q <= illegal_d;
        end
    end

    assign OutValid   = valid_q;
    assign ALUIn1     = payload_q.in1;
    assign ALUIn2     = payload_q.in2;
    assign ALUInShamt = payload_q.shamt;
    assign ALUCtrl    = payload_q.ctrl;
    assign Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: expected payloads are queued
// when an instruction is accepted and popped when the stage presents it.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  shamt;
        logic [4:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] PcPlus4;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ALUIn1;
    logic [31:0] ALUIn2;
    logic [4:0]  ALUInShamt;
    logic [4:0]  ALUCtrl;
    logic        Illegal;

    exp_t sb[$];
    exp_t held;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_issue_stage #(.DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .Instr      (Instr),
        .RsData     (RsData),
        .RtData     (RtData),
        .PcPlus4    (PcPlus4),
        .Flush      (Flush),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUIn1     (ALUIn1),
        .ALUIn2     (ALUIn2),
        .ALUInShamt (ALUInShamt),
        .ALUCtrl    (ALUCtrl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] ctrl, input logic ill);
        exp_t e;
        e.in1 = a; e.in2 = b; e.shamt = sh; e.ctrl = ctrl; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic chk_entry(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(OutValid), 32'd1);
        chk({tag, ".in1"},   ALUIn1, e.in1);
        chk({tag, ".in2"},   ALUIn2, e.in2);
        chk({tag, ".shamt"}, 32'(ALUInShamt), 32'(e.shamt));
        chk({tag, ".ctrl"},  32'(ALUCtrl), 32'(e.ctrl));
        chk({tag, ".ill"},   32'(Illegal), 32'(e.ill));
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=entry expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            held = e;
            chk_entry(tag, e);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 32'(OutValid), 32'd0);
        chk({tag, ".in1"},   ALUIn1, 32'd0);
        chk({tag, ".in2"},   ALUIn2, 32'd0);
        chk({tag, ".shamt"}, 32'(ALUInShamt), 32'd0);
        chk({tag, ".ctrl"},  32'(ALUCtrl), 32'h10);
        chk({tag, ".ill"},   32'(Illegal), 32'd0);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc);
        Instr = ins; RsData = rs; RtData = rt; PcPlus4 = pc;
    endtask

    initial begin
        rst = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_reset("reset_idle");
        chk("reset_inready", 32'(InReady), 32'd1);

        // addi, sign-extended -1
        OutReady = 1'b1; InValid = 1'b1;
        drive(32'h2128FFFF, 32'd5, 32'h0, 32'h0);
        push(32'd5, 32'hFFFFFFFF, 5'd0, 5'b00000, 1'b0);
        tick(); pop_chk("addi");

        // ori, zero-extended
        drive(32'h3528FFFF, 32'd7, 32'h0, 32'h0);
        push(32'd7, 32'h0000FFFF, 5'd0, 5'b00101, 1'b0);
        tick(); pop_chk("ori");

        // sra shamt 4
        drive(32'h00084903, 32'h11, 32'h80000000, 32'h0);
        push(32'h11, 32'h80000000, 5'd4, 5'b10011, 1'b0);
        tick(); pop_chk("sra");

        // lui 0x1234
        drive(32'h3C081234, 32'h22, 32'h0, 32'h0);
        push(32'h22, 32'h12340000, 5'd0, 5'b10101, 1'b0);
        tick(); pop_chk("lui");

        // stall three cycles with a pending add
        OutReady = 1'b0;
        drive(32'h01094020, 32'd3, 32'd4, 32'h0);
        #1;
        chk("stall_inready", 32'(InReady), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_entry("stall_hold", held);
            chk("stall_inready_hold", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        #1;
        chk("release_inready", 32'(InReady), 32'd1);
        push(32'd3, 32'd4, 5'd0, 5'b00000, 1'b0);
        tick(); pop_chk("b2b_add");

        // flush with held entry and incoming entry
        Flush = 1'b1; OutReady = 1'b0;
        drive(32'h3528AAAA, 32'd9, 32'd0, 32'h0);
        tick();
        chk_reset("flush");
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        tick();
        chk("flush_dropped", 32'(OutValid), 32'd0);

        // illegal opcode and illegal funct
        InValid = 1'b1;
        drive(32'hFC000000, 32'd9, 32'd8, 32'h0);
        push(32'd0, 32'd0, 5'd0, 5'b10000, 1'b1);
        tick(); pop_chk("illegal_op");
        drive(32'h0000003F, 32'd9, 32'd8, 32'h0);
        push(32'd0, 32'd0, 5'd0, 5'b10000, 1'b1);
        tick(); pop_chk("illegal_funct");

        // all-zero word is sll 0 (nop)
        drive(32'h00000000, 32'hA5, 32'h5A, 32'h0);
        push(32'hA5, 32'h5A, 5'd0, 5'b10001, 1'b0);
        tick(); pop_chk("nop");

        // jal
        drive(32'h0C000010, 32'h55, 32'h66, 32'h00400008);
        push(32'd0, 32'h00400008, 5'd0, 5'b10110, 1'b0);
        tick(); pop_chk("jal");

        // consumed with no new entry
        InValid = 1'b0;
        tick();
        chk("drain_valid", 32'(OutValid), 32'd0);

        // beq, then reset during a stall
        InValid = 1'b1;
        drive(32'h11090003, 32'd1, 32'd2, 32'h0);
        push(32'd1, 32'd2, 5'd0, 5'b01011, 1'b0);
        tick(); pop_chk("beq");
        OutReady = 1'b0;
        drive(32'h8D28FFFC, 32'h100, 32'h0, 32'h0);
        tick();
        chk_entry("beq_hold", held);
        rst = 1'b1;
        tick();
        chk_reset("rst_mid_stall");
        rst = 1'b0; OutReady = 1'b1;
        push(32'h100, 32'hFFFFFFFC, 5'd0, 5'b00000, 1'b0);
        tick(); pop_chk("lw_after_rst");

        InValid = 1'b0;
        tick();
        chk("final_idle", 32'(OutValid), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
